// File: rtl/fwrisc_fetch_buffer_pkg.sv
// fwrisc_fetch_buffer_pkg: shared types and sizing for the fetch buffer
package fwrisc_fetch_buffer_pkg;
    localparam int DEF_DEPTH = 4;
    localparam int PTR_W = $clog2(DEF_DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    typedef enum logic [1:0] {HIT, WAIT, MISS} lookup_t;
endpackage

// File: rtl/fwrisc_fetch_fifo.sv
// fwrisc_fetch_fifo: DEPTH-entry sync FIFO of {word address, data}; flush beats push and pop
module fwrisc_fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [29:0]              push_addr,
    input  logic [31:0]              push_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [29:0]              head_addr,
    output logic [31:0]              head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [AW-1:0] rd, wr;
    assign head_addr = addr_q[rd];
    assign head_data = data_q[rd];
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                addr_q[wr] <= push_addr;
                data_q[wr] <= push_data;
                wr         <= wr + 1'b1;
            end
            if (pop) rd <= rd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fwrisc_fetch_buffer.sv
// fwrisc_fetch_buffer: sequential prefetch FIFO between the fwrisc core and instruction memory.
// Define FWRISC_FETCH_BUF_STATS_EN to add hit_count/miss_count outputs.
module fwrisc_fetch_buffer
    import fwrisc_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic [31:0] idata,
    output logic        iready,
    output logic [31:0] maddr,
    output logic        mvalid,
    input  logic [31:0] mdata,
    input  logic        mready
`ifdef FWRISC_FETCH_BUF_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    state_t state, state_nx;
    lookup_t lookup;
    logic active, empty, hit, miss, push;
    logic [29:0] f, d, head_addr;
    logic [31:0] head_data;
    logic [CW-1:0] count, count_nx;
    logic unused_iaddr;
    assign unused_iaddr = ^iaddr[1:0];
    assign empty = count == '0;
    assign lookup = (!empty && iaddr[31:2] == head_addr) ? HIT :
                    (empty && active && iaddr[31:2] == f) ? WAIT : MISS;
    assign hit = ivalid && lookup == HIT;
    assign miss = ivalid && lookup == MISS;
    assign iready = hit;
    assign idata = hit ? head_data : '0;
    assign mvalid = state != IDLE;
    assign maddr = state == REQ ? {f, 2'b00} : state == DISCARD ? {d, 2'b00} : '0;
    // a redirect in the same cycle as a return drops the returned word
    assign push = state == REQ && mready && !miss;
    assign count_nx = miss ? '0 : count + CW'(push) - CW'(hit);
    // a request is issued only while its slot is guaranteed free on return
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (active || miss) && count_nx < FULL ? REQ : IDLE;
            REQ:     state_nx = miss && !mready ? DISCARD : mready && count_nx == FULL ? IDLE : REQ;
            DISCARD: state_nx = mready ? REQ : DISCARD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            active <= 1'b0;
            f      <= '0;
            d      <= '0;
        end else begin
            state <= state_nx;
            if (miss) begin
                f      <= iaddr[31:2];
                active <= 1'b1;
            end else if (push) begin
                f <= f + 30'd1;
            end
            if (state == REQ && miss && !mready) d <= f;
        end
    end
    fwrisc_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (hit),
        .flush     (miss),
        .push_addr (f),
        .push_data (mdata),
        .count     (count),
        .head_addr (head_addr),
        .head_data (head_data)
    );
`ifdef FWRISC_FETCH_BUF_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) hit_count <= hit_count + 32'd1;
            if (miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fwrisc_fetch_buffer.sv
// tb_fwrisc_fetch_buffer: directed self-checking bench with a latency-configurable memory responder
module tb_fwrisc_fetch_buffer;
    import fwrisc_fetch_buffer_pkg::*;
    logic clock = 1'b0, reset = 1'b1, ivalid = 1'b0, mready = 1'b0;
    logic iready, mvalid;
    logic [31:0] iaddr = '0, mdata = '0, idata, maddr;
    int checks = 0, errors = 0, lat = 1, cnt = 0;
    bit stall = 1'b0;
`ifdef FWRISC_FETCH_BUF_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    fwrisc_fetch_buffer #(.DEPTH(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .iaddr  (iaddr),
        .ivalid (ivalid),
        .idata  (idata),
        .iready (iready),
        .maddr  (maddr),
        .mvalid (mvalid),
        .mdata  (mdata),
        .mready (mready)
`ifdef FWRISC_FETCH_BUF_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // memory: answers each request after lat wait cycles unless stalled
    always @(posedge clock) begin
        #1;
        if (reset || !mvalid) begin
            mready = 1'b0;
            cnt = 0;
        end else if (stall) begin
            mready = 1'b0;
        end else if (mready) begin
            mready = 1'b0;
            cnt = 1;
        end else if (cnt >= lat) begin
            mready = 1'b1;
            mdata = word(maddr);
        end else begin
            cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b1; ivalid = 1'b0; stall = 1'b0; lat = 1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_ready(output int cyc, output logic [31:0] data);
        cyc = 0;
        #1;
        while (!iready && cyc < 100) begin
            @(posedge clock); #3;
            cyc++;
        end
        data = idata;
        checks++;
        if (iready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout addr=%h iready=%b required 1", iaddr, iready);
        end
    endtask

    task automatic fetch(input logic [31:0] a, output int cyc, output logic [31:0] data);
        ivalid = 1'b1;
        iaddr = a;
        wait_ready(cyc, data);
        @(posedge clock); #2;
        ivalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #3;
        checks += 4;
        if (mvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %b required 0", mvalid); end
        if (maddr !== 32'h0) begin errors++; $display("FAIL reset_maddr got %h required 0", maddr); end
        if (iready !== 1'b0) begin errors++; $display("FAIL reset_iready got %b required 0", iready); end
        if (idata !== 32'h0) begin errors++; $display("FAIL reset_idata got %h required 0", idata); end
        @(posedge clock); #2;
        reset = 1'b0;
        idle(3);
        #1;
        checks++;
        if (mvalid !== 1'b0) begin errors++; $display("FAIL no_speculative_fetch mvalid=%b required 0", mvalid); end
        @(posedge clock); #2;
    endtask

    task automatic test_sequential();
        int cyc;
        logic [31:0] data;
        fetch(32'h100, cyc, data);
        checks += 2;
        if (data !== word(32'h100)) begin errors++; $display("FAIL seq_data0 got %h required %h", data, word(32'h100)); end
        if (cyc != 3) begin errors++; $display("FAIL seq_miss_latency got %0d required 3", cyc); end
        for (int i = 1; i < 8; i++) begin
            idle(2);
            fetch(32'h100 + 32'(4 * i), cyc, data);
            checks += 2;
            if (data !== word(32'h100 + 32'(4 * i)))
                begin errors++; $display("FAIL seq_data%0d got %h required %h", i, data, word(32'h100 + 32'(4 * i))); end
            if (cyc != 0) begin errors++; $display("FAIL seq_hit_latency%0d got %0d required 0", i, cyc); end
        end
    endtask

    task automatic test_branch_full();
        int cyc;
        logic [31:0] data;
        idle(12);
        #1;
        checks += 2;
        if (dut.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d required 4", dut.count); end
        if (mvalid !== 1'b0) begin errors++; $display("FAIL full_mvalid got %b required 0", mvalid); end
        #1;
        ivalid = 1'b1;
        iaddr = 32'h200;
        #1;
        checks += 2;
        if (iready !== 1'b0) begin errors++; $display("FAIL branch_no_stale iready=%b required 0", iready); end
        if (idata !== 32'h0) begin errors++; $display("FAIL branch_idata_zero got %h required 0", idata); end
        @(posedge clock); #3;
        checks += 2;
        if (mvalid !== 1'b1) begin errors++; $display("FAIL branch_mvalid got %b required 1", mvalid); end
        if (maddr !== 32'h200) begin errors++; $display("FAIL branch_maddr got %h required 200", maddr); end
        wait_ready(cyc, data);
        checks++;
        if (data !== word(32'h200)) begin errors++; $display("FAIL branch_data got %h required %h", data, word(32'h200)); end
        @(posedge clock); #2;
        ivalid = 1'b0;
    endtask

    task automatic test_redirect();
        int cyc;
        logic [31:0] data;
        do_reset();
        fetch(32'h100, cyc, data);
        #1;
        for (int i = 0; i < 20 && !(mvalid && maddr == 32'h108 && !mready); i++) begin
            @(posedge clock); #3;
        end
        checks++;
        if (!(mvalid && maddr == 32'h108 && !mready))
            begin errors++; $display("FAIL redirect_setup maddr=%h mvalid=%b required 108/1", maddr, mvalid); end
        stall = 1'b1;
        ivalid = 1'b1;
        iaddr = 32'h300;
        @(posedge clock); #3;
        checks += 3;
        if (dut.state !== DISCARD) begin errors++; $display("FAIL redirect_state got %0d required DISCARD", dut.state); end
        if (maddr !== 32'h108) begin errors++; $display("FAIL redirect_maddr_held got %h required 108", maddr); end
        if (mvalid !== 1'b1) begin errors++; $display("FAIL redirect_mvalid got %b required 1", mvalid); end
        repeat (2) begin @(posedge clock); #3; end
        stall = 1'b0;
        for (int i = 0; i < 20 && dut.state == DISCARD; i++) begin
            @(posedge clock); #3;
        end
        checks++;
        if (maddr !== 32'h300) begin errors++; $display("FAIL redirect_new_maddr got %h required 300", maddr); end
        wait_ready(cyc, data);
        checks++;
        if (data !== word(32'h300)) begin errors++; $display("FAIL redirect_data got %h required %h", data, word(32'h300)); end
        @(posedge clock); #2;
        ivalid = 1'b0;
    endtask

    task automatic test_pop_push();
        int cyc;
        logic [31:0] data;
        do_reset();
        fetch(32'h500, cyc, data);
        checks++;
        if (data !== word(32'h500)) begin errors++; $display("FAIL pp_first got %h required %h", data, word(32'h500)); end
        #1;
        for (int i = 0; i < 30 && !(dut.count == 3'd3 && mready && maddr == 32'h510); i++) begin
            @(posedge clock); #3;
        end
        checks++;
        if (!(dut.count == 3'd3 && mready && maddr == 32'h510))
            begin errors++; $display("FAIL pp_setup count=%0d maddr=%h required 3/510", dut.count, maddr); end
        ivalid = 1'b1;
        iaddr = 32'h504;
        #1;
        checks += 2;
        if (iready !== 1'b1) begin errors++; $display("FAIL pp_hit iready=%b required 1", iready); end
        if (idata !== word(32'h504)) begin errors++; $display("FAIL pp_data got %h required %h", idata, word(32'h504)); end
        @(posedge clock); #2;
        ivalid = 1'b0;
        #1;
        checks += 3;
        if (dut.count !== 3'd3) begin errors++; $display("FAIL pp_count got %0d required 3", dut.count); end
        if (mvalid !== 1'b1) begin errors++; $display("FAIL pp_mvalid got %b required 1", mvalid); end
        if (maddr !== 32'h514) begin errors++; $display("FAIL pp_maddr got %h required 514", maddr); end
        @(posedge clock); #2;
    endtask

    task automatic test_wrap();
        int cyc;
        logic [31:0] data;
        do_reset();
        fetch(32'hFFFF_FFFC, cyc, data);
        checks++;
        if (data !== word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_top got %h required %h", data, word(32'hFFFF_FFFC)); end
        #1;
        for (int i = 0; i < 10 && !(mvalid && maddr == 32'h0); i++) begin
            @(posedge clock); #3;
        end
        checks++;
        if (!(mvalid && maddr == 32'h0)) begin errors++; $display("FAIL wrap_maddr got %h required 0", maddr); end
        @(posedge clock); #2;
        idle(4);
        fetch(32'h0, cyc, data);
        checks += 2;
        if (cyc != 0) begin errors++; $display("FAIL wrap_hit_latency got %0d required 0", cyc); end
        if (data !== word(32'h0)) begin errors++; $display("FAIL wrap_data got %h required %h", data, word(32'h0)); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [31:0] data;
        do_reset();
        stall = 1'b1;
        ivalid = 1'b1;
        iaddr = 32'h600;
        @(posedge clock); #3;
        checks++;
        if (mvalid !== 1'b1) begin errors++; $display("FAIL rm_mvalid_before got %b required 1", mvalid); end
        reset = 1'b1;
        ivalid = 1'b0;
        @(posedge clock); #3;
        checks += 2;
        if (mvalid !== 1'b0) begin errors++; $display("FAIL rm_mvalid_after got %b required 0", mvalid); end
        if (dut.count !== 3'd0) begin errors++; $display("FAIL rm_count got %0d required 0", dut.count); end
        @(posedge clock); #2;
        reset = 1'b0;
        stall = 1'b0;
        fetch(32'h400, cyc, data);
        checks += 2;
        if (data !== word(32'h400)) begin errors++; $display("FAIL rm_data got %h required %h", data, word(32'h400)); end
        if (cyc != 3) begin errors++; $display("FAIL rm_latency got %0d required 3", cyc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_full();
        test_redirect();
        test_pop_push();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
